// File: rtl/encoder_4_2_sync_pkg.sv
// Shared types and sizing constants for the registered priority encoder.
// The FSM encoding is fixed so the state bit can be observed on a bus if needed.
package encoder_4_2_sync_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int ENC_N = 4;
    localparam int ENC_W = $clog2(ENC_N);

endpackage

// File: rtl/encoder_4_2_sync_prio_enc_n.sv
// Combinational highest-index-wins encoder: bit N-1 has top priority.
// A zero input yields index 0 with any=0.
module prio_enc_n #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    always_comb begin
        idx = '0;
        // Ascending scan so the last (highest) set bit overwrites lower ones.
        for (int k = 0; k < N; k++) begin
            if (vec[k]) begin
                idx = W'(k);
            end
        end
        any = |vec;
    end

endmodule

// File: rtl/encoder_4_2_sync.sv
// Registered priority encoder with sticky pending lines and a valid/ack handshake.
// The presented code is held until accepted; accepted lines are cleared from pending.
module encoder_4_2_sync
    import encoder_4_2_sync_pkg::*;
#(
    parameter int N = ENC_N,
    parameter int W = ENC_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         En,
    input  logic [N-1:0] I,
    output logic [W-1:0] Y,
    output logic         V,
    input  logic         Ack,
    output logic [N-1:0] Pend,
    output logic         Err
);

    if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
        $error("encoder_4_2_sync: N must be a power of two and at least 2");
    end
    if (W != $clog2(N)) begin : g_bad_w
        $error("encoder_4_2_sync: W must equal clog2(N)");
    end

    state_t         state;
    state_t         state_next;
    logic [N-1:0]   pend;
    logic [N-1:0]   capt;
    logic [N-1:0]   clr;
    logic [N-1:0]   masked;
    logic [N-1:0]   sel;
    logic [W-1:0]   y_q;
    logic [W-1:0]   y_next;
    logic [W-1:0]   idx;
    logic           v_q;
    logic           v_next;
    logic           err_q;
    logic           any;
    logic           fire;

    always_comb begin
        capt   = En ? I : '0;
        fire   = v_q & Ack;
        clr    = fire ? (N'(1) << y_q) : '0;
        masked = pend & ~clr;
        // In HOLD the line being accepted must not be re-selected this cycle.
        sel    = (state == HOLD) ? masked : pend;
    end

    prio_enc_n #(
        .N (N),
        .W (W)
    ) u_prio (
        .vec (sel),
        .idx (idx),
        .any (any)
    );

    always_comb begin
        state_next = state;
        y_next     = y_q;
        v_next     = v_q;
        case (state)
            IDLE: begin
                if (any) begin
                    y_next     = idx;
                    v_next     = 1'b1;
                    state_next = HOLD;
                end else begin
                    v_next = 1'b0;
                end
            end
            HOLD: begin
                // No preemption: the code only changes on acceptance.
                if (fire) begin
                    if (any) begin
                        y_next = idx;
                    end else begin
                        v_next     = 1'b0;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                v_next     = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pend  <= '0;
            y_q   <= '0;
            v_q   <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state <= state_next;
            // Set wins over clear when a line is accepted and re-requested together.
            pend  <= masked | capt;
            y_q   <= y_next;
            v_q   <= v_next;
            err_q <= err_q | (|(capt & masked));
        end
    end

    assign Y    = y_q;
    assign V    = v_q;
    assign Pend = pend;
    assign Err  = err_q;

endmodule
